// File: rtl/clint_pkg.sv
// rtl/clint_pkg.sv - shared offsets, response codes, FSM states and decode types for clint_mt
package clint_pkg;

    localparam logic [15:0] MSIP_OFF     = 16'h0000;
    localparam logic [15:0] MTIMECMP_OFF = 16'h4000;
    localparam logic [15:0] MTIME_OFF    = 16'hBFF8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        RD_IDLE,
        RD_RESP
    } rd_state_t;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_WAIT_W,
        WR_WAIT_AW,
        WR_RESP
    } wr_state_t;

    typedef enum logic [2:0] {
        DEC_NONE,
        DEC_MSIP,
        DEC_CMP_LO,
        DEC_CMP_HI,
        DEC_MTIME_LO,
        DEC_MTIME_HI
    } dec_kind_t;

    typedef struct packed {
        dec_kind_t  kind;
        logic [3:0] hart;
    } dec_t;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] r;
        r = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) r[8*b +: 8] = new_val[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/axi_lite_if.sv
// rtl/axi_lite_if.sv - 32-bit AXI4-Lite bundle with master and slave views
interface axi_lite_if;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/clint_prescaler.sv
// rtl/clint_prescaler.sv - divides clk by TICK_DIV, one-cycle tick on counter wrap
module clint_prescaler #(
    parameter int TICK_DIV = 1
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // With TICK_DIV = 1 the counter sits at 0 and tick is permanently high.
    assign tick  = (cnt_q == LAST);
    assign cnt_d = tick ? '0 : cnt_q + CW'(1);

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/clint_mt.sv
// rtl/clint_mt.sv - multi-hart core-local interruptor: mtime, mtimecmp, msip behind AXI4-Lite
module clint_mt
    import clint_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
    parameter int          NUM_HARTS = 1,
    parameter int          TICK_DIV  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    axi_lite_if.slave            s,
    output logic [NUM_HARTS-1:0] mtip,
    output logic [NUM_HARTS-1:0] msip_o
);
    localparam logic [15:0] MTIME_HI_OFF = MTIME_OFF + 16'h4;

    logic                 tick;
    logic [63:0]          mtime_q, mtime_d;
    logic [63:0]          mtimecmp_q [NUM_HARTS];
    logic [63:0]          mtimecmp_d [NUM_HARTS];
    logic [NUM_HARTS-1:0] msip_q, msip_d, mtip_q, mtip_d;

    rd_state_t   rd_state_q, rd_state_d;
    logic [31:0] rdata_q, rdata_d, rd_val;
    logic [1:0]  rresp_q, rresp_d;
    dec_t        rd_dec;

    wr_state_t   wr_state_q, wr_state_d;
    logic [31:2] awaddr_q, awaddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [1:0]  bresp_q, bresp_d;
    dec_t        wr_dec;

    logic        commit;
    logic [31:2] cm_addr;
    logic [31:0] cm_data;
    logic [3:0]  cm_strb;

    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{s.araddr[1:0], s.awaddr[1:0]};

    function automatic dec_t decode(input logic [31:2] addr);
        dec_t        d;
        logic [13:0] waddr, msip_idx;
        logic [12:0] cmp_idx;
        waddr    = addr[15:2];
        msip_idx = waddr - MSIP_OFF[15:2];
        cmp_idx  = waddr[13:1] - MTIMECMP_OFF[15:3];
        d.kind   = DEC_NONE;
        d.hart   = '0;
        if (addr[31:16] == BASE_ADDR[31:16]) begin
            if (waddr < MTIMECMP_OFF[15:2]) begin
                if (int'(msip_idx) < NUM_HARTS) begin
                    d.kind = DEC_MSIP;
                    d.hart = msip_idx[3:0];
                end
            end else if (waddr == MTIME_OFF[15:2]) begin
                d.kind = DEC_MTIME_LO;
            end else if (waddr == MTIME_HI_OFF[15:2]) begin
                d.kind = DEC_MTIME_HI;
            end else if (int'(cmp_idx) < NUM_HARTS) begin
                d.kind = waddr[0] ? DEC_CMP_HI : DEC_CMP_LO;
                d.hart = cmp_idx[3:0];
            end
        end
        return d;
    endfunction

    clint_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    always_comb begin
        rd_dec = decode(s.araddr[31:2]);
        rd_val = '0;
        case (rd_dec.kind)
            DEC_MTIME_LO: rd_val = mtime_q[31:0];
            DEC_MTIME_HI: rd_val = mtime_q[63:32];
            default: ;
        endcase
        for (int h = 0; h < NUM_HARTS; h++) begin
            if (rd_dec.hart == 4'(h)) begin
                case (rd_dec.kind)
                    DEC_MSIP:   rd_val = {31'b0, msip_q[h]};
                    DEC_CMP_LO: rd_val = mtimecmp_q[h][31:0];
                    DEC_CMP_HI: rd_val = mtimecmp_q[h][63:32];
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        s.arready  = 1'b0;
        s.rvalid   = 1'b0;
        case (rd_state_q)
            RD_IDLE: begin
                s.arready = 1'b1;
                if (s.arvalid) begin
                    rdata_d    = rd_val;
                    rresp_d    = (rd_dec.kind == DEC_NONE) ? RESP_SLVERR : RESP_OKAY;
                    rd_state_d = RD_RESP;
                end
            end
            RD_RESP: begin
                s.rvalid = 1'b1;
                if (s.rready) rd_state_d = RD_IDLE;
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    // The half that arrives second is taken straight off the bus; the first is held.
    always_comb begin
        wr_state_d = wr_state_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        commit     = 1'b0;
        cm_addr    = s.awaddr[31:2];
        cm_data    = s.wdata;
        cm_strb    = s.wstrb;
        s.awready  = 1'b0;
        s.wready   = 1'b0;
        s.bvalid   = 1'b0;
        case (wr_state_q)
            WR_IDLE: begin
                s.awready = 1'b1;
                s.wready  = 1'b1;
                if (s.awvalid && s.wvalid) begin
                    commit     = 1'b1;
                    wr_state_d = WR_RESP;
                end else if (s.awvalid) begin
                    awaddr_d   = s.awaddr[31:2];
                    wr_state_d = WR_WAIT_W;
                end else if (s.wvalid) begin
                    wdata_d    = s.wdata;
                    wstrb_d    = s.wstrb;
                    wr_state_d = WR_WAIT_AW;
                end
            end
            WR_WAIT_W: begin
                s.wready = 1'b1;
                cm_addr  = awaddr_q;
                if (s.wvalid) begin
                    commit     = 1'b1;
                    wr_state_d = WR_RESP;
                end
            end
            WR_WAIT_AW: begin
                s.awready = 1'b1;
                cm_data   = wdata_q;
                cm_strb   = wstrb_q;
                if (s.awvalid) begin
                    commit     = 1'b1;
                    wr_state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                s.bvalid = 1'b1;
                if (s.bready) wr_state_d = WR_IDLE;
            end
            default: wr_state_d = WR_IDLE;
        endcase
    end

    always_comb begin
        wr_dec     = decode(cm_addr);
        mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
        mtimecmp_d = mtimecmp_q;
        msip_d     = msip_q;
        bresp_d    = bresp_q;
        if (commit) begin
            bresp_d = (wr_dec.kind == DEC_NONE) ? RESP_SLVERR : RESP_OKAY;
            // A strobed mtime write replaces this cycle's increment; the prescaler keeps running.
            if (|cm_strb) begin
                case (wr_dec.kind)
                    DEC_MTIME_LO: mtime_d = {mtime_q[63:32], merge_bytes(mtime_q[31:0], cm_data, cm_strb)};
                    DEC_MTIME_HI: mtime_d = {merge_bytes(mtime_q[63:32], cm_data, cm_strb), mtime_q[31:0]};
                    default: ;
                endcase
            end
            for (int h = 0; h < NUM_HARTS; h++) begin
                if (wr_dec.hart == 4'(h)) begin
                    case (wr_dec.kind)
                        DEC_MSIP:   if (cm_strb[0]) msip_d[h] = cm_data[0];
                        DEC_CMP_LO: mtimecmp_d[h][31:0]  = merge_bytes(mtimecmp_q[h][31:0], cm_data, cm_strb);
                        DEC_CMP_HI: mtimecmp_d[h][63:32] = merge_bytes(mtimecmp_q[h][63:32], cm_data, cm_strb);
                        default: ;
                    endcase
                end
            end
        end
    end

    always_comb begin
        mtip_d = '0;
        for (int h = 0; h < NUM_HARTS; h++) begin
            mtip_d[h] = (mtime_q >= mtimecmp_q[h]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mtime_q    <= '0;
            mtimecmp_q <= '{default: '1};
            msip_q     <= '0;
            mtip_q     <= '0;
            rd_state_q <= RD_IDLE;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
            wr_state_q <= WR_IDLE;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bresp_q    <= RESP_OKAY;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            msip_q     <= msip_d;
            mtip_q     <= mtip_d;
            rd_state_q <= rd_state_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            wr_state_q <= wr_state_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bresp_q    <= bresp_d;
        end
    end

    assign s.rdata = rdata_q;
    assign s.rresp = rresp_q;
    assign s.bresp = bresp_q;
    assign mtip    = mtip_q;
    assign msip_o  = msip_q;
endmodule

// File: tb/tb_clint_mt.sv
// tb/tb_clint_mt.sv - directed self-checking bench for clint_mt (2 harts, TICK_DIV 4)
module tb_clint_mt;
    localparam logic [31:0] BASE   = 32'h0200_0000;
    localparam logic [31:0] A_MSIP0 = BASE + 32'h0000;
    localparam logic [31:0] A_MSIP1 = BASE + 32'h0004;
    localparam logic [31:0] A_MSIP5 = BASE + 32'h0014;
    localparam logic [31:0] A_CMP0L = BASE + 32'h4000;
    localparam logic [31:0] A_CMP0H = BASE + 32'h4004;
    localparam logic [31:0] A_CMP1L = BASE + 32'h4008;
    localparam logic [31:0] A_CMP1H = BASE + 32'h400C;
    localparam logic [31:0] A_BAD   = BASE + 32'hBFF0;
    localparam logic [31:0] A_MTL   = BASE + 32'hBFF8;
    localparam logic [31:0] A_MTH   = BASE + 32'hBFFC;
    localparam int          TMO     = 50;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] mtip;
    logic [1:0] msip_o;
    int         errors = 0;
    int         checks = 0;

    axi_lite_if bus ();

    clint_mt #(.BASE_ADDR(BASE), .NUM_HARTS(2), .TICK_DIV(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .s      (bus),
        .mtip   (mtip),
        .msip_o (msip_o)
    );

    always #5 clk = ~clk;

    task automatic timeout(input string what);
        checks++;
        errors++;
        $display("FAIL %s: handshake timeout, got no response within %0d cycles", what, TMO);
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int n;
        data = 'x;
        resp = 'x;
        @(negedge clk);
        bus.araddr  = addr;
        bus.arvalid = 1'b1;
        n = 0;
        while (!bus.arready) begin
            @(negedge clk);
            if (++n > TMO) begin timeout("ar"); bus.arvalid = 1'b0; return; end
        end
        @(posedge clk);
        #1 bus.arvalid = 1'b0;
        bus.rready = 1'b1;
        @(negedge clk);
        n = 0;
        while (!bus.rvalid) begin
            @(negedge clk);
            if (++n > TMO) begin timeout("r"); bus.rready = 1'b0; return; end
        end
        data = bus.rdata;
        resp = bus.rresp;
        @(posedge clk);
        #1 bus.rready = 1'b0;
    endtask

    task automatic wr_req(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly);
        bit aw_done, w_done, aw_fire, w_fire;
        int cyc;
        aw_done = 0;
        w_done  = 0;
        cyc     = 0;
        while (!(aw_done && w_done)) begin
            @(negedge clk);
            bus.awaddr  = addr;
            bus.wdata   = data;
            bus.wstrb   = strb;
            bus.awvalid = !aw_done && (cyc >= aw_dly);
            bus.wvalid  = !w_done && (cyc >= w_dly);
            aw_fire = bus.awvalid && bus.awready;
            w_fire  = bus.wvalid && bus.wready;
            @(posedge clk);
            aw_done = aw_done || aw_fire;
            w_done  = w_done || w_fire;
            #1;
            if (aw_done) bus.awvalid = 1'b0;
            if (w_done)  bus.wvalid  = 1'b0;
            if (++cyc > TMO) begin
                timeout("aw/w");
                bus.awvalid = 1'b0;
                bus.wvalid  = 1'b0;
                return;
            end
        end
    endtask

    task automatic wr_resp(output logic [1:0] resp);
        int n;
        resp = 'x;
        bus.bready = 1'b1;
        @(negedge clk);
        n = 0;
        while (!bus.bvalid) begin
            @(negedge clk);
            if (++n > TMO) begin timeout("b"); bus.bready = 1'b0; return; end
        end
        resp = bus.bresp;
        @(posedge clk);
        #1 bus.bready = 1'b0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                      output logic [1:0] resp);
        wr_req(addr, data, strb, 0, 0);
        wr_resp(resp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic [1:0]  r;
        do_reset();
        checks++;
        if ({bus.arready, bus.awready, bus.wready, bus.rvalid, bus.bvalid} !== 5'b11100) begin
            errors++;
            $display("FAIL reset_hs: got %b expected 11100",
                     {bus.arready, bus.awready, bus.wready, bus.rvalid, bus.bvalid});
        end
        checks++;
        if ({mtip, msip_o} !== 4'b0000) begin
            errors++; $display("FAIL reset_irq: got %b expected 0000", {mtip, msip_o});
        end
        rd(A_CMP1H, d, r);
        checks++;
        if ({d, r} !== {32'hFFFF_FFFF, 2'b00}) begin
            errors++; $display("FAIL reset_cmp1h: got %h/%b expected ffffffff/00", d, r);
        end
        rd(A_MTH, d, r);
        checks++;
        if ({d, r} !== {32'h0, 2'b00}) begin
            errors++; $display("FAIL reset_mth: got %h/%b expected 00000000/00", d, r);
        end
    endtask

    task automatic test_mtime_count();
        logic [31:0] a, b;
        logic [1:0]  r;
        rd(A_MTL, a, r);
        repeat (40) @(posedge clk);
        rd(A_MTL, b, r);
        // Samples are 42 clocks apart, so 10 or 11 ticks at TICK_DIV 4.
        checks++;
        if (!((b - a) >= 32'd10 && (b - a) <= 32'd11)) begin
            errors++; $display("FAIL mtime_count: got delta %0d expected 10..11", b - a);
        end
    endtask

    task automatic test_mtip();
        logic [31:0] d;
        logic [1:0]  r;
        int          n;
        wr(A_CMP1L, 32'h40, 4'hF, r);
        checks++;
        if (r !== 2'b00) begin errors++; $display("FAIL cmp1l_bresp: got %b expected 00", r); end
        wr(A_CMP1H, 32'h0, 4'hF, r);
        checks++;
        if (r !== 2'b00) begin errors++; $display("FAIL cmp1h_bresp: got %b expected 00", r); end
        checks++;
        if (mtip !== 2'b00) begin errors++; $display("FAIL mtip_early: got %b expected 00", mtip); end
        n = 0;
        while (mtip[1] !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (mtip !== 2'b10) begin errors++; $display("FAIL mtip_rise: got %b expected 10", mtip); end
        rd(A_MTL, d, r);
        checks++;
        if (!(d >= 32'h40 && d <= 32'h41)) begin
            errors++; $display("FAIL mtip_mtime: got %h expected 40..41", d);
        end
    endtask

    task automatic test_msip();
        logic [31:0] d;
        logic [1:0]  r;
        wr_req(A_MSIP0, 32'h1, 4'hF, 3, 0);
        checks++;
        if ({msip_o, bus.bvalid} !== 3'b011) begin
            errors++; $display("FAIL msip_commit: got %b expected 011", {msip_o, bus.bvalid});
        end
        wr_resp(r);
        checks++;
        if (r !== 2'b00) begin errors++; $display("FAIL msip_bresp: got %b expected 00", r); end
        rd(A_MSIP0, d, r);
        checks++;
        if ({d, r} !== {32'h1, 2'b00}) begin
            errors++; $display("FAIL msip0_rd: got %h/%b expected 00000001/00", d, r);
        end
        wr(A_MSIP0, 32'h0, 4'h0, r);
        checks++;
        if ({msip_o, r} !== 4'b0100) begin
            errors++; $display("FAIL msip_strb0: got %b expected 0100", {msip_o, r});
        end
        wr(A_MSIP1, 32'hFFFF_FFFF, 4'hF, r);
        rd(A_MSIP1, d, r);
        checks++;
        if ({msip_o, d} !== {2'b11, 32'h1}) begin
            errors++; $display("FAIL msip1_bits: got %b/%h expected 11/00000001", msip_o, d);
        end
        wr(A_MSIP1, 32'h0, 4'hF, r);
        checks++;
        if (msip_o !== 2'b01) begin errors++; $display("FAIL msip1_clr: got %b expected 01", msip_o); end
    endtask

    task automatic test_mtime_strobe();
        logic [31:0] d;
        logic [1:0]  r;
        wr(A_MTL, 32'h1234_0000, 4'hF, r);
        wr(A_MTL, 32'hFFFF_FF00, 4'b0011, r);
        checks++;
        if (r !== 2'b00) begin errors++; $display("FAIL mtl_bresp: got %b expected 00", r); end
        rd(A_MTL, d, r);
        checks++;
        if (!(d[31:16] == 16'h1234 && d[15:0] >= 16'hFF00 && d[15:0] <= 16'hFF07)) begin
            errors++; $display("FAIL mtl_strobe: got %h expected 1234ff00..1234ff07", d);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] lo, hi;
        logic [1:0]  r;
        wr(A_MTH, 32'hFFFF_FFFF, 4'hF, r);
        wr(A_MTL, 32'hFFFF_FFFF, 4'hF, r);
        repeat (8) @(posedge clk);
        rd(A_MTL, lo, r);
        rd(A_MTH, hi, r);
        checks++;
        if (!(hi == 32'h0 && lo < 32'd8)) begin
            errors++; $display("FAIL mtime_wrap: got %h_%h expected 00000000_0000000x", hi, lo);
        end
        checks++;
        if (mtip !== 2'b00) begin errors++; $display("FAIL wrap_mtip: got %b expected 00", mtip); end
    endtask

    task automatic test_slverr();
        logic [31:0] d;
        logic [1:0]  r;
        rd(A_BAD, d, r);
        checks++;
        if ({d, r} !== {32'h0, 2'b10}) begin
            errors++; $display("FAIL bad_rd: got %h/%b expected 00000000/10", d, r);
        end
        wr(A_MSIP5, 32'h1, 4'hF, r);
        checks++;
        if ({r, msip_o} !== 4'b1001) begin
            errors++; $display("FAIL msip5_wr: got %b expected 1001", {r, msip_o});
        end
        rd(A_MSIP5, d, r);
        checks++;
        if ({d, r} !== {32'h0, 2'b10}) begin
            errors++; $display("FAIL msip5_rd: got %h/%b expected 00000000/10", d, r);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic [1:0]  r;
        bit          saw_bvalid;
        @(negedge clk);
        bus.awaddr  = A_CMP0L;
        bus.awvalid = 1'b1;
        @(posedge clk);
        #1 bus.awvalid = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.awready, bus.wready} !== 2'b01) begin
            errors++; $display("FAIL wait_w: got %b expected 01", {bus.awready, bus.wready});
        end
        do_reset();
        saw_bvalid = 0;
        bus.bready = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (bus.bvalid) saw_bvalid = 1;
        end
        bus.bready = 1'b0;
        checks++;
        if ({saw_bvalid, bus.awready} !== 2'b01) begin
            errors++; $display("FAIL post_reset_b: got %b expected 01", {saw_bvalid, bus.awready});
        end
        rd(A_CMP0L, d, r);
        checks++;
        if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL cmp0l_rst: got %h expected ffffffff", d); end
        rd(A_CMP0H, d, r);
        checks++;
        if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL cmp0h_rst: got %h expected ffffffff", d); end
        rd(A_CMP1L, d, r);
        checks++;
        if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL cmp1l_rst: got %h expected ffffffff", d); end
        checks++;
        if ({mtip, msip_o} !== 4'b0000) begin
            errors++; $display("FAIL irq_rst: got %b expected 0000", {mtip, msip_o});
        end
    endtask

    initial begin
        bus.awaddr  = '0;
        bus.awvalid = 1'b0;
        bus.wdata   = '0;
        bus.wstrb   = '0;
        bus.wvalid  = 1'b0;
        bus.bready  = 1'b0;
        bus.araddr  = '0;
        bus.arvalid = 1'b0;
        bus.rready  = 1'b0;
        test_reset();
        test_mtime_count();
        test_mtip();
        test_msip();
        test_mtime_strobe();
        test_wrap();
        test_slverr();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/clint_mt.md
# clint_mt

Multi-hart AXI4-Lite core-local interruptor, successor to the single read-only mtime slave. It provides a free-running 64-bit mtime with a programmable prescaler and per-hart mtimecmp and msip registers, all writable with byte strobes. It drives per-hart timer and software interrupt lines to the cores and sits on the AXI4-Lite crossbar as a slave.

## Interface
- BASE_ADDR, 32'h0200_0000, region base; 64 KiB aligned.
- NUM_HARTS, 1, hart count, 1..16.
- TICK_DIV, 1, clk cycles per mtime increment, 1..65535.
- clk  in  1  clock.
- reset  in  1  reset: synchronous, active-high.
- s  axi_lite_if.slave  32-bit data  AXI4-Lite slave port.
- mtip  out  NUM_HARTS  timer interrupt pending, per hart.
- msip_o  out  NUM_HARTS  software interrupt pending, per hart.

## Operation
- Register map, offsets from BASE_ADDR:
  - msip[h] at 0x0000+4h; bit 0 only; other bits read 0 and ignore writes.
  - mtimecmp[h] at 0x4000+8h (lo) and +4 (hi).
  - mtime at 0xBFF8 (lo) and 0xBFFC (hi).
- Any other address, or h >= NUM_HARTS: read returns rdata 0 with rresp SLVERR (2'b10); a write changes nothing and returns bresp SLVERR. Mapped accesses return OKAY (2'b00).
- Prescaler: a counter runs 0..TICK_DIV-1 and asserts tick on wrap. mtime += 1 on tick, wrapping modulo 2^64.
- An mtime write replaces the strobed bytes of the addressed half. It takes priority over the increment in the same cycle, and the prescaler is not reset.
- mtip[h] = (mtime >= mtimecmp[h]), unsigned 64-bit compare, registered.
- msip_o[h] = msip[h] bit 0.
- wstrb is honoured per byte on every register. wstrb == 0 is a legal no-op and returns OKAY.
- Read FSM states are RD_IDLE and RD_RESP.
  - RD_IDLE: arready = 1. On AR handshake, decode, register rdata/rresp, and go to RD_RESP.
  - RD_RESP: rvalid = 1. On R handshake, return to RD_IDLE.
- Write FSM states are WR_IDLE, WR_WAIT_W, WR_WAIT_AW and WR_RESP.
  - AW and W are accepted independently and in either order.
  - awready = 1 in WR_IDLE and WR_WAIT_AW. wready = 1 in WR_IDLE and WR_WAIT_W.
  - Both in the same cycle in WR_IDLE: commit, then go to WR_RESP.
  - Only AW: go to WR_WAIT_W. Only W: go to WR_WAIT_AW.
  - Commit happens in the cycle the second half arrives.
  - WR_RESP: bvalid = 1. On B handshake, return to WR_IDLE.
- The read and write channels are fully independent.

## Timing
- Reset values:
  - mtime = 0 and prescaler = 0.
  - mtimecmp[*] = 64'hFFFF_FFFF_FFFF_FFFF.
  - msip = 0, mtip = 0, msip_o = 0.
  - arready = awready = wready = 1; rvalid = bvalid = 0.
  - Both FSMs go to idle.
- Reset mid-transaction drops the transaction. No response is issued after reset.
- Read latency: rvalid rises 1 cycle after the AR handshake. rdata is sampled at the AR handshake and held stable until the R handshake.
- Write latency: bvalid rises 1 cycle after the commit cycle. The register holds the new value from the cycle after commit.
- mtip updates 1 cycle after the mtime or mtimecmp change that causes it.
- Read and write to the same register in the same cycle: the read returns the pre-write value.
- TICK_DIV = 1: mtime increments every cycle.
- A 64-bit read is two 32-bit reads. Software handles hi/lo tearing; no shadow register is provided.

## Structure
- clint_pkg: region offsets (MSIP_OFF, MTIMECMP_OFF, MTIME_OFF), rd_state_t, wr_state_t, RESP_OKAY, RESP_SLVERR.
- Sub-module clint_prescaler (parameter TICK_DIV; ports clk, reset, tick).
- Top level contains: address decode, register file (mtime, mtimecmp array, msip vector), both FSMs, and the comparators.

## Test plan
- Reset, TICK_DIV=1 -> read mtime lo twice, 10 cycles apart: values differ by 10 ± handshake cycles; mtip = 0, msip_o = 0.
- NUM_HARTS=2, TICK_DIV=4 -> write mtimecmp[1] = 64'h40 (lo then hi) -> mtip[1] rises when mtime reaches 0x40, i.e. about 256 cycles; mtip[0] stays 0.
- Write msip[0] = 32'h1 with W presented 3 cycles before AW -> msip_o[0] = 1 the cycle after commit; bresp OKAY; readback 32'h1.
- Write mtime lo = 32'hFFFF_FFFF with wstrb = 4'b0011 -> only the low 16 bits change.
- Write mtime to 64'hFFFF_FFFF_FFFF_FFFF -> mtime wraps to 0.
- Read 0xBFF0 and write msip[5] with NUM_HARTS=2 -> rdata 0 with SLVERR; bresp SLVERR; no register changes.
- Assert reset while in WR_WAIT_W -> after reset, bvalid stays 0, awready = 1, and mtimecmp = all ones.
